// File: rtl/maxpool_row_sched.sv
// maxpool_row_sched: 2x2 max-pooling row scheduler.
// Pairs consecutive input rows of a DIMxDIM frame and emits one pooled row
// (DIM/2 pixels) per pair over a valid/ready output.
// Optional build macro MAXPOOL_SIGNED_EN: compare pixels as two's-complement
// signed values instead of unsigned.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for start
// LOAD_EVEN | accepting the even (upper) row of a pair into row_buf
// LOAD_ODD  | accepting the odd row; pooled result registered on the beat
// EMIT      | pooled row presented, waiting for out_ready
// FIN       | one-cycle done pulse, then back to IDLE
module maxpool_row_sched #(
   parameter int BITS = 8,
   parameter int DIM  = 32,
   localparam int HALF = DIM / 2,
   localparam int IW   = (HALF > 1) ? $clog2(HALF) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   output logic                 busy,
   output logic                 done,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [BITS*DIM-1:0]  in_row,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [BITS*HALF-1:0] out_row,
   output logic [IW-1:0]        out_idx
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LOAD_EVEN = 3'd1,
      LOAD_ODD  = 3'd2,
      EMIT      = 3'd3,
      FIN       = 3'd4
   } state_t;

   state_t                state;
   state_t                state_nxt;
   logic [IW-1:0]         row_cnt;
   logic [BITS*DIM-1:0]   row_buf;
   logic [BITS*HALF-1:0]  pooled;
   logic                  beat;
   logic                  last_row;

   function automatic logic [BITS-1:0] pix_max(input logic [BITS-1:0] a,
                                               input logic [BITS-1:0] b);
`ifdef MAXPOOL_SIGNED_EN
      return ($signed(a) >= $signed(b)) ? a : b;
`else
      return (a >= b) ? a : b;
`endif
   endfunction

   assign beat     = in_valid && in_ready;
   assign last_row = (row_cnt == IW'(HALF - 1));

   // 2x2 window max of the buffered even row and the incoming odd row
   always_comb begin
      pooled = '0;
      for (int k = 0; k < HALF; k++) begin
         pooled[k*BITS +: BITS] =
            pix_max(pix_max(row_buf[(2*k)*BITS +: BITS], row_buf[(2*k+1)*BITS +: BITS]),
                    pix_max(in_row[(2*k)*BITS +: BITS],  in_row[(2*k+1)*BITS +: BITS]));
      end
   end

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // next-state and state-decoded outputs; in_ready depends only on state
   always_comb begin
      state_nxt = state;
      busy      = 1'b1;
      done      = 1'b0;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) state_nxt = LOAD_EVEN;
         end
         LOAD_EVEN: begin
            in_ready = 1'b1;
            if (beat) state_nxt = LOAD_ODD;
         end
         LOAD_ODD: begin
            in_ready = 1'b1;
            if (beat) state_nxt = EMIT;
         end
         EMIT: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = last_row ? FIN : LOAD_EVEN;
         end
         FIN: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            busy      = 1'b0;
            state_nxt = IDLE;
         end
      endcase
   end

   // row counter, even-row buffer and registered pooled output
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_cnt <= '0;
         row_buf <= '0;
         out_row <= '0;
         out_idx <= '0;
      end else begin
         if (state == IDLE && start)
            row_cnt <= '0;
         else if (state == EMIT && out_ready && !last_row)
            row_cnt <= row_cnt + IW'(1);
         if (state == LOAD_EVEN && beat)
            row_buf <= in_row;
         if (state == LOAD_ODD && beat) begin
            out_row <= pooled;
            out_idx <= row_cnt;
         end
      end
   end

endmodule

// File: tb/tb_maxpool_row_sched.sv
// Randomized self-checking bench for maxpool_row_sched (DIM=4, BITS=8).
module tb_maxpool_row_sched;
   localparam int BITS = 8;
   localparam int DIM  = 4;
   localparam int HALF = DIM / 2;
   localparam int IW   = (HALF > 1) ? $clog2(HALF) : 1;
   localparam int W    = BITS * DIM;
   localparam int OW   = BITS * HALF;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic          busy;
   logic          done;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_row;
   logic          out_valid;
   logic          out_ready;
   logic [OW-1:0] out_row;
   logic [IW-1:0] out_idx;

   maxpool_row_sched #(.BITS(BITS), .DIM(DIM)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
      .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_row(out_row), .out_idx(out_idx)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [OW-1:0] row;
      logic [IW-1:0] idx;
   } exp_t;

   int            errors = 0;
   int            checks = 0;
   int            beats = 0;
   int            done_cnt = 0;
   int            ready_pct = 100;
   logic [W-1:0]  frame [DIM];
   exp_t          exp_q [$];
   logic [OW-1:0] log_row [$];
   logic [IW-1:0] log_idx [$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // pixel value as a plain integer in the active comparison domain
   function automatic int pix_val(input logic [BITS-1:0] p);
`ifdef MAXPOOL_SIGNED_EN
      return int'($signed(p));
`else
      return int'(p);
`endif
   endfunction

   // expected pooled rows of the current frame
   function automatic void push_model();
      for (int p = 0; p < HALF; p++) begin
         exp_t e;
         e.row = '0;
         e.idx = IW'(p);
         for (int k = 0; k < HALF; k++) begin
            logic [BITS-1:0] cand [4];
            logic [BITS-1:0] best;
            cand[0] = frame[2*p][(2*k)*BITS +: BITS];
            cand[1] = frame[2*p][(2*k+1)*BITS +: BITS];
            cand[2] = frame[2*p+1][(2*k)*BITS +: BITS];
            cand[3] = frame[2*p+1][(2*k+1)*BITS +: BITS];
            best = cand[0];
            for (int i = 1; i < 4; i++)
               if (pix_val(cand[i]) > pix_val(best)) best = cand[i];
            e.row[k*BITS +: BITS] = best;
         end
         exp_q.push_back(e);
      end
   endfunction

   function automatic logic [W-1:0] rand_row();
      logic [W-1:0] r;
      for (int c = 0; c < DIM; c++) r[c*BITS +: BITS] = BITS'($urandom);
      return r;
   endfunction

   // downstream ready generator
   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         out_ready = ($urandom_range(0, 99) < ready_pct);
      end
   end

   // compare process: scoreboard, stall stability, done timing
   logic          stall_prev = 1'b0;
   logic [OW-1:0] prev_row;
   logic [IW-1:0] prev_idx;
   always @(negedge clk) begin
      if (!rst_n) begin
         stall_prev = 1'b0;
      end else begin
         if (in_valid && in_ready) beats++;
         if (out_valid) chk("in_ready_in_emit", in_ready, 1'b0);
         if (stall_prev) begin
            chk("stall_valid", out_valid, 1'b1);
            chk("stall_row", out_row, prev_row);
            chk("stall_idx", out_idx, prev_idx);
         end
         if (out_valid && out_ready) begin
            chk("out_expected", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
               exp_t e;
               e = exp_q.pop_front();
               chk("out_row", out_row, e.row);
               chk("out_idx", out_idx, e.idx);
            end
            log_row.push_back(out_row);
            log_idx.push_back(out_idx);
         end
         if (done) begin
            done_cnt++;
            chk("done_after_last", exp_q.size(), 0);
         end
         stall_prev = out_valid && !out_ready;
         prev_row   = out_row;
         prev_idx   = out_idx;
      end
   end

   task automatic do_start();
      @(posedge clk);
      #1;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("busy_after_start", busy, 1'b1);
      push_model();
   endtask

   task automatic feed_frame(input int pct);
      int   r = 0;
      int   cyc = 0;
      logic acc;
      while (r < DIM) begin
         in_valid = ($urandom_range(0, 99) < pct);
         in_row   = in_valid ? frame[r] : rand_row();
         @(negedge clk);
         acc = in_valid && in_ready;
         @(posedge clk);
         #1;
         if (acc) r++;
         cyc++;
         if (cyc > 2000) begin
            chk("feed_timeout", 1'b1, 1'b0);
            break;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int c = 0;
      int d0 = done_cnt;
      while (done_cnt == d0 && c < budget) begin
         @(posedge clk);
         c++;
      end
      repeat (3) @(posedge clk);
      chk("done_pulses", done_cnt - d0, 1);
   endtask

   task automatic run_frame(input int pct);
      log_row.delete();
      log_idx.delete();
      do_start();
      feed_frame(pct);
      wait_done(500);
      chk("frame_outputs", log_row.size(), HALF);
   endtask

   task automatic load_basic();
      frame[0] = 32'h04030201;
      frame[1] = 32'h08070605;
      frame[2] = 32'h09000009;
      frame[3] = 32'h00090900;
   endtask

   task automatic check_basic_log(input string tag);
      if (log_row.size() == 2) begin
         chk({tag, "_row0"}, log_row[0], 16'h0806);
         chk({tag, "_idx0"}, log_idx[0], 0);
         chk({tag, "_row1"}, log_row[1], 16'h0909);
         chk({tag, "_idx1"}, log_idx[1], 1);
      end else begin
         chk({tag, "_count"}, log_row.size(), 2);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n    = 1'b0;
      start    = 1'b0;
      in_valid = 1'b0;
      in_row   = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 1'b0);
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_out_row", out_row, 0);
      chk("rst_out_idx", out_idx, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_busy", busy, 1'b0);

      // basic frame, always ready
      load_basic();
      ready_pct = 100;
      run_frame(100);
      check_basic_log("basic");

      // unsigned / signed max corner
      frame[0] = 32'h000001FF;
      frame[1] = 32'h0000807F;
      frame[2] = '0;
      frame[3] = '0;
      run_frame(100);
`ifdef MAXPOOL_SIGNED_EN
      if (log_row.size() > 0) chk("max_corner", log_row[0], 16'h007F);
`else
      if (log_row.size() > 0) chk("max_corner", log_row[0], 16'h00FF);
`endif

      // backpressure: hold out_ready low 5 cycles in EMIT
      load_basic();
      log_row.delete();
      log_idx.delete();
      ready_pct = 0;
      do_start();
      fork
         feed_frame(100);
         begin
            int   c = 0;
            int   b0;
            logic [OW-1:0] req_row;
            req_row = exp_q[0].row;
            while (!out_valid && c < 100) begin
               @(negedge clk);
               c++;
            end
            chk("bp_reached_emit", out_valid, 1'b1);
            b0 = beats;
            repeat (5) begin
               @(negedge clk);
               chk("bp_valid", out_valid, 1'b1);
               chk("bp_in_ready", in_ready, 1'b0);
               chk("bp_row", out_row, req_row);
               chk("bp_beats", beats - b0, 0);
            end
            ready_pct = 100;
         end
      join
      wait_done(500);
      check_basic_log("bp");

      // start while busy (LOAD_EVEN of row 2) is ignored
      log_row.delete();
      log_idx.delete();
      do_start();
      fork
         feed_frame(100);
         begin
            int c = 0;
            while (log_row.size() < 1 && c < 200) begin
               @(posedge clk);
               c++;
            end
            #1;
            chk("swb_in_load_even", in_ready && !out_valid, 1'b1);
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
         end
      join
      wait_done(500);
      repeat (4) @(negedge clk);
      chk("swb_outputs", log_row.size(), HALF);
      chk("swb_idle_after", busy, 1'b0);

      // in_valid gaps give the same results
      run_frame(50);
      check_basic_log("gaps");

      // reset in LOAD_ODD abandons the frame
      do_start();
      in_row   = frame[0];
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("pre_rst_in_ready", in_ready, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_in_ready", in_ready, 1'b0);
      chk("mid_rst_out_valid", out_valid, 1'b0);
      chk("mid_rst_done", done, 1'b0);
      chk("mid_rst_out_row", out_row, 0);
      chk("mid_rst_out_idx", out_idx, 0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      run_frame(100);
      check_basic_log("post_rst");

      // random frames with random gaps and backpressure
      ready_pct = 60;
      for (int f = 0; f < 6; f++) begin
         for (int r = 0; r < DIM; r++) frame[r] = rand_row();
         run_frame(50);
      end
      ready_pct = 100;
      repeat (3) @(negedge clk);
      chk("final_queue_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
